// File: rtl/params_noc.sv
// params_noc: shared NoC flit types.
// Flit labels and the VC-less flit bundle carried on the link.
package params_noc;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t flit_label;
    logic [3:0]  x_Dest;
    logic [3:0]  y_Dest;
    logic [7:0]  data;
  } flit_Data_noVC;

endpackage

// File: rtl/flit_link_tx.sv
// flit_link_tx: link transmitter with framing check and skid store.
// Ports: clk, rst_n (async, active-low); in_flit/in_valid/in_ready from
// the local source; on_off_i = downstream buf_On_Off; out_flit/out_valid
// = downstream input_Data/write_i; err_o = one-cycle drop pulse.
// Build option FLIT_TX_STATS_EN adds pkt_sent_o and flit_sent_o.
module flit_link_tx
  import params_noc::*;
#(
  parameter int SKID_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  flit_Data_noVC in_flit,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          on_off_i,
  output flit_Data_noVC out_flit,
  output logic          out_valid,
  output logic          err_o
`ifdef FLIT_TX_STATS_EN
  ,
  output logic [15:0]   pkt_sent_o,
  output logic [15:0]   flit_sent_o
`endif
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(SKID_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PKT  = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  flit_Data_noVC mem [SKID_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic accept;
  logic legal;
  logic push;
  logic pop;
  logic is_head;
  logic is_body;
  logic is_tail;
  logic is_ht;
  logic idle;

  assign is_head = in_flit.flit_label == HEAD;
  assign is_body = in_flit.flit_label == BODY;
  assign is_tail = in_flit.flit_label == TAIL;
  assign is_ht   = in_flit.flit_label == HEADTAIL;
  assign idle    = state == S_IDLE;

  always_comb begin
    legal     = 1'b0;
    state_nxt = state;
    unique case (1'b1)
      idle && is_head: begin
        legal     = 1'b1;
        state_nxt = S_PKT;
      end
      idle && is_ht: begin
        legal = 1'b1;
      end
      !idle && is_body: begin
        legal = 1'b1;
      end
      !idle && is_tail: begin
        legal     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        legal     = 1'b0;
        state_nxt = state;
      end
    endcase
  end

  // Violating flits are consumed (accept) but never stored (push).
  assign accept  = in_valid & in_ready;
  assign push    = accept & legal;
  assign pop     = (cnt != '0) & on_off_i;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      err_o     <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_flit;
        wr_ptr      <= wr_ptr + PW'(1);
        state       <= state_nxt;
      end
      if (pop) begin
        out_flit <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      out_valid <= pop;
      cnt       <= cnt_nxt;
      // Registered ready looks at post-edge occupancy, so a pop at
      // this edge reopens the input immediately after it.
      in_ready  <= cnt_nxt < FULL;
      err_o     <= accept & ~legal;
    end
  end

`ifdef FLIT_TX_STATS_EN
  logic pkt_end;

  assign pkt_end = (mem[rd_ptr].flit_label == TAIL) |
                   (mem[rd_ptr].flit_label == HEADTAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_sent_o  <= '0;
      flit_sent_o <= '0;
    end else if (pop) begin
      flit_sent_o <= flit_sent_o + 16'd1;
      if (pkt_end) begin
        pkt_sent_o <= pkt_sent_o + 16'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_flit_link_tx.sv
// tb_flit_link_tx: randomized and directed bench for flit_link_tx.
// Queue-based reference model compared against the DUT every cycle.
module tb_flit_link_tx;
  import params_noc::*;

  localparam int DEPTH = 2;

  logic          clk;
  logic          rst_n;
  flit_Data_noVC in_flit;
  logic          in_valid;
  logic          in_ready;
  logic          on_off_i;
  flit_Data_noVC out_flit;
  logic          out_valid;
  logic          err_o;
`ifdef FLIT_TX_STATS_EN
  logic [15:0]   pkt_sent_o;
  logic [15:0]   flit_sent_o;
`endif

  flit_link_tx #(.SKID_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .on_off_i   (on_off_i),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .err_o      (err_o)
`ifdef FLIT_TX_STATS_EN
    ,
    .pkt_sent_o (pkt_sent_o),
    .flit_sent_o(flit_sent_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic flit_Data_noVC mk(input flit_label_t l, input int x,
                                       input int y, input int d);
    flit_Data_noVC f;
    f.flit_label = l;
    f.x_Dest     = 4'(x);
    f.y_Dest     = 4'(y);
    f.data       = 8'(d);
    return f;
  endfunction

  // ---------------- reference model ----------------
  flit_Data_noVC mq[$];
  bit            m_inpkt = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_ready = 1'b0;
  bit            m_err   = 1'b0;
  flit_Data_noVC m_out   = '0;
  logic [15:0]   m_pkt   = '0;
  logic [15:0]   m_flit  = '0;
  bit            m_acc;
  bit            m_ok;
  flit_label_t   m_lbl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_inpkt = 1'b0;
      m_valid = 1'b0;
      m_ready = 1'b0;
      m_err   = 1'b0;
      m_out   = '0;
      m_pkt   = '0;
      m_flit  = '0;
    end else begin
      m_acc = in_valid && m_ready;
      m_lbl = in_flit.flit_label;
      if (!m_inpkt) m_ok = (m_lbl == HEAD) || (m_lbl == HEADTAIL);
      else          m_ok = (m_lbl == BODY) || (m_lbl == TAIL);
      if (mq.size() > 0 && on_off_i) begin
        m_out   = mq.pop_front();
        m_valid = 1'b1;
        m_flit  = m_flit + 16'd1;
        if (m_out.flit_label == TAIL || m_out.flit_label == HEADTAIL)
          m_pkt = m_pkt + 16'd1;
      end else begin
        m_valid = 1'b0;
      end
      if (m_acc && m_ok) begin
        mq.push_back(in_flit);
        m_inpkt = (m_lbl == HEAD) || (m_lbl == BODY);
      end
      m_err   = m_acc && !m_ok;
      m_ready = mq.size() < DEPTH;
    end
  end

  // ---------------- compare + monitor ----------------
  int            cyc = 0;
  flit_Data_noVC seen[$];
  int            seen_cyc[$];
  int            err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("err_o", 64'(err_o), 64'(m_err));
    chk("out_flit", 64'(out_flit), 64'(m_out));
`ifdef FLIT_TX_STATS_EN
    chk("pkt_sent", 64'(pkt_sent_o), 64'(m_pkt));
    chk("flit_sent", 64'(flit_sent_o), 64'(m_flit));
`endif
    if (out_valid) begin
      seen.push_back(out_flit);
      seen_cyc.push_back(cyc);
    end
    if (err_o) err_cnt++;
  end

  // ---------------- stimulus ----------------
  int last_acc;
  bit sent_ok;
  bit got;
  bit wr_done;
  int base;
  int ebase;
  int h_acc;
`ifdef FLIT_TX_STATS_EN
  logic [15:0] pbase;
`endif

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input flit_Data_noVC f);
    sent_ok  = 1'b0;
    in_flit  = f;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !sent_ok; i++) begin
      if (in_ready) begin
        last_acc = cyc + 1;
        sent_ok  = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("send_accept", 64'(sent_ok), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_flit  = '0;
    on_off_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'(1));

    // Basic path
    on_off_i = 1'b1;
    base = seen.size();
    send(mk(HEAD, 1, 2, 8'h11));
    h_acc = last_acc;
    send(mk(BODY, 1, 2, 8'h12));
    send(mk(TAIL, 1, 2, 8'h13));
    idle(4);
    chk("basic_n", 64'(seen.size() - base), 64'(3));
    if (seen.size() >= base + 3) begin
      chk("basic_l0", 64'(seen[base].flit_label), 64'(HEAD));
      chk("basic_x", 64'(seen[base].x_Dest), 64'(1));
      chk("basic_y", 64'(seen[base].y_Dest), 64'(2));
      chk("basic_l1", 64'(seen[base+1].flit_label), 64'(BODY));
      chk("basic_l2", 64'(seen[base+2].flit_label), 64'(TAIL));
      chk("basic_lat", 64'(seen_cyc[base] - h_acc), 64'(1));
      chk("basic_b2b", 64'(seen_cyc[base+2] - seen_cyc[base]), 64'(2));
    end
`ifdef FLIT_TX_STATS_EN
    chk("basic_pkt", 64'(pkt_sent_o), 64'(1));
    chk("basic_flit", 64'(flit_sent_o), 64'(3));
`endif

    // Backpressure
    on_off_i = 1'b0;
    idle(1);
    base = seen.size();
    send(mk(HEADTAIL, 0, 0, 8'h21));
    send(mk(HEADTAIL, 0, 0, 8'h22));
    chk("bp_full", 64'(in_ready), 64'(0));
    in_flit  = mk(HEADTAIL, 0, 0, 8'h23);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", 64'(in_ready), 64'(0));
    end
    chk("bp_none", 64'(seen.size() - base), 64'(0));
    on_off_i = 1'b1;
    send(mk(HEADTAIL, 0, 0, 8'h23));
    idle(4);
    chk("bp_n", 64'(seen.size() - base), 64'(3));
    for (int k = 0; k < 3; k++)
      if (seen.size() > base + k)
        chk("bp_ord", 64'(seen[base+k].data), 64'(8'h21 + k));

    // Mid-packet stall
    base = seen.size();
    got  = 1'b0;
    fork
      begin
        send(mk(HEAD, 3, 3, 8'h30));
        send(mk(BODY, 3, 3, 8'h31));
        send(mk(BODY, 3, 3, 8'h32));
        send(mk(TAIL, 3, 3, 8'h33));
      end
      begin
        for (int i = 0; i < 100 && !got; i++) begin
          @(negedge clk);
          if (out_valid && out_flit.flit_label == BODY) got = 1'b1;
        end
        chk("stall_watch", 64'(got), 64'(1));
        on_off_i = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_quiet", 64'(out_valid), 64'(0));
        end
        on_off_i = 1'b1;
      end
    join
    idle(5);
    chk("stall_n", 64'(seen.size() - base), 64'(4));
    for (int k = 0; k < 4; k++)
      if (seen.size() > base + k)
        chk("stall_ord", 64'(seen[base+k].data), 64'(8'h30 + k));

    // Framing: BODY while idle
    base  = seen.size();
    ebase = err_cnt;
    send(mk(BODY, 0, 0, 8'h40));
    idle(3);
    chk("fe_body_err", 64'(err_cnt - ebase), 64'(1));
    chk("fe_body_out", 64'(seen.size() - base), 64'(0));

    // Framing: HEAD, HEAD, TAIL
    ebase = err_cnt;
    send(mk(HEAD, 0, 0, 8'h41));
    send(mk(HEAD, 0, 0, 8'h42));
    send(mk(TAIL, 0, 0, 8'h43));
    idle(3);
    chk("fe_hh_err", 64'(err_cnt - ebase), 64'(1));
    chk("fe_hh_n", 64'(seen.size() - base), 64'(2));
    if (seen.size() >= base + 2) begin
      chk("fe_hh_0", 64'(seen[base].data), 64'(8'h41));
      chk("fe_hh_1", 64'(seen[base+1].data), 64'(8'h43));
    end

    // Wrap-around with toggling on_off
    base    = seen.size();
    wr_done = 1'b0;
`ifdef FLIT_TX_STATS_EN
    pbase = pkt_sent_o;
`endif
    fork
      begin
        for (int y = 0; y < 10; y++) send(mk(HEADTAIL, 5, y, 8'h50 + y));
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          idle(2);
          on_off_i = ~on_off_i;
        end
        on_off_i = 1'b1;
      end
    join
    idle(6);
    chk("wrap_n", 64'(seen.size() - base), 64'(10));
    for (int k = 0; k < 10; k++)
      if (seen.size() > base + k)
        chk("wrap_y", 64'(seen[base+k].y_Dest), 64'(k));
`ifdef FLIT_TX_STATS_EN
    chk("wrap_pkt", 64'(pkt_sent_o - pbase), 64'(10));
`endif

    // Reset mid-operation
    on_off_i = 1'b0;
    send(mk(HEAD, 6, 6, 8'h60));
    send(mk(BODY, 6, 6, 8'h61));
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_ready", 64'(in_ready), 64'(0));
    chk("mrst_err", 64'(err_o), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    on_off_i = 1'b1;
    base  = seen.size();
    ebase = err_cnt;
    idle(3);
    chk("mrst_stale", 64'(seen.size() - base), 64'(0));
    send(mk(TAIL, 6, 6, 8'h62));
    idle(3);
    chk("mrst_tail_err", 64'(err_cnt - ebase), 64'(1));
    chk("mrst_tail_out", 64'(seen.size() - base), 64'(0));

    // Randomized traffic
    repeat (400) begin
      in_valid = $urandom_range(0, 2) != 0;
      in_flit  = mk(flit_label_t'($urandom_range(0, 3)),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 255));
      on_off_i = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    on_off_i = 1'b1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
